// File: rtl/draw_pkg.sv
// Shared definitions for the draw-path region reader and writer.
// Both sides sweep the same pair window, so the geometry lives here.
package draw_pkg;

   localparam int DRAW_ADDR_W    = 14;
   localparam int DRAW_DATA_W    = 8;
   localparam int DRAW_BASE_PAIR = 7936;
   localparam int DRAW_PAIRS     = 128;

   // Pair index covers up to 256 pairs; count must also represent 256 itself.
   localparam int PAIR_IDX_W = 8;
   localparam int COUNT_W    = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FLUSH = 2'd2
   } wr_state_t;

   // Increment that sticks at the limit instead of running past it.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                   input logic [COUNT_W-1:0] lim);
      if (v >= lim) begin
         return lim;
      end
      return v + COUNT_W'(1);
   endfunction

endpackage

// File: rtl/pair_addr_gen.sv
// Pair index counter and pair address formation for a fixed pair window.
// The caller appends the even/odd bit to obtain the two port addresses.
module pair_addr_gen
   import draw_pkg::*;
#(
   parameter int PAIR_W    = DRAW_ADDR_W - 1,
   parameter int BASE_PAIR = DRAW_BASE_PAIR,
   parameter int PAIRS     = DRAW_PAIRS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              step,
   output logic [PAIR_W-1:0] pair_addr,
   output logic              last
);

   localparam logic [PAIR_W-1:0]     BASE     = PAIR_W'(BASE_PAIR);
   localparam logic [PAIR_IDX_W-1:0] LAST_IDX = PAIR_IDX_W'(PAIRS - 1);

   logic [PAIR_IDX_W-1:0] idx;

   // Index restarts on clear and advances per step, parking on the last pair.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx <= '0;
      end else if (clear) begin
         idx <= '0;
      end else if (step && !last) begin
         idx <= idx + PAIR_IDX_W'(1);
      end
   end

   assign last = (idx == LAST_IDX);

   // Window placement guarantees BASE+idx never wraps at PAIR_W bits.
   assign pair_addr = BASE + PAIR_W'(idx);

endmodule

// File: rtl/pair_region_writer.sv
// Writes a stream of data pairs into a fixed dual-port RAM window:
// even word on port A, odd word on port B, one pair per accepted beat.
module pair_region_writer
   import draw_pkg::*;
#(
   parameter int ADDR_W    = DRAW_ADDR_W,
   parameter int DATA_W    = DRAW_DATA_W,
   parameter int BASE_PAIR = DRAW_BASE_PAIR,
   parameter int PAIRS     = DRAW_PAIRS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data_a,
   input  logic [DATA_W-1:0]  in_data_b,
   output logic [ADDR_W-1:0]  addr_a,
   output logic [ADDR_W-1:0]  addr_b,
   output logic [DATA_W-1:0]  wdata_a,
   output logic [DATA_W-1:0]  wdata_b,
   output logic               we_a,
   output logic               we_b,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] count
);

   localparam int                PAIR_W    = ADDR_W - 1;
   localparam logic [PAIR_W-1:0] BASE      = PAIR_W'(BASE_PAIR);
   localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(PAIRS);

   wr_state_t         state;
   logic              beat_p0;
   logic              step_p0;
   logic              clear_p0;
   logic              last_p0;
   logic [PAIR_W-1:0] pair_p0;

   // Stage p0: handshake; a beat landing together with abort is dropped.
   assign in_ready = (state == FILL);
   assign beat_p0  = in_valid & in_ready;
   assign step_p0  = beat_p0 & ~abort;
   assign clear_p0 = (state == IDLE) & start & ~abort;

   pair_addr_gen #(
      .PAIR_W    (PAIR_W),
      .BASE_PAIR (BASE_PAIR),
      .PAIRS     (PAIRS)
   ) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_p0),
      .step      (step_p0),
      .pair_addr (pair_p0),
      .last      (last_p0)
   );

   // Fill sequencing: IDLE -> FILL on start, FILL -> FLUSH on the last pair,
   // FLUSH -> IDLE with a done pulse; abort returns to IDLE silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         count <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (clear_p0) begin
                  state <= FILL;
                  busy  <= 1'b1;
                  count <= '0;
               end
            end
            FILL: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (beat_p0) begin
                  count <= sat_inc(count, COUNT_MAX);
                  if (last_p0) begin
                     state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (!abort) begin
                  done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Stage p1: registered write ports; address and data hold between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_a  <= {BASE, 1'b0};
         addr_b  <= {BASE, 1'b1};
         wdata_a <= '0;
         wdata_b <= '0;
         we_a    <= 1'b0;
         we_b    <= 1'b0;
      end else if (step_p0) begin
         addr_a  <= {pair_p0, 1'b0};
         addr_b  <= {pair_p0, 1'b1};
         wdata_a <= in_data_a;
         wdata_b <= in_data_b;
         we_a    <= 1'b1;
         we_b    <= 1'b1;
      end else begin
         we_a <= 1'b0;
         we_b <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pair_region_writer.sv
// Directed-plus-random bench for pair_region_writer. The reference model
// tracks only "is a fill active", "pairs taken so far" and "all pairs taken",
// and derives the expected port values from plain window arithmetic.
module tb_pair_region_writer;

   localparam int ADDR_W    = 14;
   localparam int DATA_W    = 8;
   localparam int BASE_PAIR = 7936;
   localparam int PAIRS     = 128;

   logic              clk;
   logic              reset;
   logic              start;
   logic              abort;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data_a;
   logic [DATA_W-1:0] in_data_b;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] wdata_a;
   logic [DATA_W-1:0] wdata_b;
   logic              we_a;
   logic              we_b;
   logic              busy;
   logic              done;
   logic [8:0]        count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit m_busy   = 0;
   bit m_all_in = 0;
   int m_k      = 0;
   int e_addr_a = 2 * BASE_PAIR;
   int e_addr_b = 2 * BASE_PAIR + 1;
   int e_wa     = 0;
   int e_wb     = 0;
   bit e_we     = 0;
   bit e_done   = 0;

   pair_region_writer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data_a (in_data_a),
      .in_data_b (in_data_b),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .wdata_a   (wdata_a),
      .wdata_b   (wdata_b),
      .we_a      (we_a),
      .we_b      (we_b),
      .busy      (busy),
      .done      (done),
      .count     (count)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_ports();
      chk("we_a",    32'(we_a),    32'(e_we));
      chk("we_b",    32'(we_b),    32'(e_we));
      chk("addr_a",  32'(addr_a),  32'(e_addr_a));
      chk("addr_b",  32'(addr_b),  32'(e_addr_b));
      chk("wdata_a", 32'(wdata_a), 32'(e_wa));
      chk("wdata_b", 32'(wdata_b), 32'(e_wb));
      chk("busy",    32'(busy),    32'(m_busy));
      chk("done",    32'(done),    32'(e_done));
      chk("count",   32'(count),   32'(m_k));
   endtask

   // One clock cycle: drive inputs, check ready, advance, update model, check outputs.
   task automatic cyc(input bit v, input logic [7:0] da, input logic [7:0] db,
                      input bit st, input bit ab);
      bit rdy;
      bit beat;
      in_valid  = v;
      in_data_a = da;
      in_data_b = db;
      start     = st;
      abort     = ab;
      rdy  = m_busy && !m_all_in;
      beat = v && rdy;
      #1;
      chk("in_ready", 32'(in_ready), 32'(rdy));
      @(posedge clk);
      #1;
      e_we   = 0;
      e_done = 0;
      if (m_busy && ab) begin
         m_busy   = 0;
         m_all_in = 0;
      end else if (m_busy && m_all_in) begin
         m_busy   = 0;
         m_all_in = 0;
         e_done   = 1;
      end else if (m_busy) begin
         if (beat) begin
            e_we     = 1;
            e_addr_a = 2 * (BASE_PAIR + m_k);
            e_addr_b = 2 * (BASE_PAIR + m_k) + 1;
            e_wa     = int'(da);
            e_wb     = int'(db);
            m_k++;
            if (m_k == PAIRS) m_all_in = 1;
         end
      end else if (st && !ab) begin
         m_busy = 1;
         m_k    = 0;
      end
      check_ports();
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      int guard;

      reset     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      in_valid  = 1'b0;
      in_data_a = '0;
      in_data_b = '0;

      // 1: reset values, then release with idle inputs
      repeat (3) @(posedge clk);
      #1;
      check_ports();
      chk("reset_addr_a_abs", 32'(addr_a), 32'd15872);
      chk("reset_addr_b_abs", 32'(addr_b), 32'd15873);
      reset = 1'b1;
      repeat (3) cyc(0, 8'd0, 8'd0, 0, 0);

      // start together with abort in IDLE: stays idle
      cyc(0, 8'd0, 8'd0, 1, 1);
      chk("start_abort_idle_busy", 32'(busy), 32'd0);
      cyc(0, 8'd0, 8'd0, 0, 0);

      // 2: back-to-back fill with data k / k+128
      cyc(0, 8'd0, 8'd0, 1, 0);
      for (int k = 0; k < PAIRS; k++) begin
         cyc(1, 8'(k), 8'(k + 128), 0, 0);
         if (k == 0) begin
            chk("first_addr_a", 32'(addr_a), 32'd15872);
            chk("first_data_b", 32'(wdata_b), 32'd128);
         end
         if (k == PAIRS - 1) begin
            chk("last_addr_a", 32'(addr_a), 32'd16126);
            chk("last_addr_b", 32'(addr_b), 32'd16127);
            chk("last_data_a", 32'(wdata_a), 32'd127);
            chk("last_data_b", 32'(wdata_b), 32'd255);
         end
      end
      cyc(0, 8'd0, 8'd0, 0, 0);
      chk("fill2_done", 32'(done), 32'd1);
      chk("fill2_count", 32'(count), 32'd128);
      cyc(0, 8'd0, 8'd0, 0, 0);

      // 3: in_valid toggling every other cycle, random data
      cyc(0, 8'd0, 8'd0, 1, 0);
      guard = 0;
      while (!m_all_in && guard < 400) begin
         ra = 8'($urandom());
         rb = 8'($urandom());
         cyc(guard[0] == 1'b0, ra, rb, 0, 0);
         guard++;
      end
      chk("fill3_all_in", 32'(m_all_in), 32'd1);
      cyc(0, 8'd0, 8'd0, 0, 0);
      chk("fill3_done", 32'(done), 32'd1);
      cyc(0, 8'd0, 8'd0, 0, 0);

      // 4: start pulsed again at beat 40 is ignored
      cyc(0, 8'd0, 8'd0, 1, 0);
      for (int k = 0; k < PAIRS; k++) begin
         ra = 8'($urandom());
         rb = 8'($urandom());
         cyc(1, ra, rb, k == 40, 0);
         if (k == 41) chk("restart_ignored_addr_a", 32'(addr_a), 32'd15954);
      end
      cyc(0, 8'd0, 8'd0, 0, 0);
      chk("fill4_count", 32'(count), 32'd128);
      cyc(0, 8'd0, 8'd0, 0, 0);

      // 5: abort together with beat 60
      cyc(0, 8'd0, 8'd0, 1, 0);
      for (int k = 0; k <= 60; k++) begin
         ra = 8'($urandom());
         rb = 8'($urandom());
         cyc(1, ra, rb, 0, k == 60);
      end
      chk("abort_we", 32'(we_a), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_count", 32'(count), 32'd60);
      cyc(0, 8'd0, 8'd0, 0, 0);
      cyc(0, 8'd0, 8'd0, 1, 0);
      for (int k = 0; k < 5; k++) begin
         ra = 8'($urandom());
         rb = 8'($urandom());
         cyc(1, ra, rb, 0, 0);
         if (k == 0) chk("refill_addr_a", 32'(addr_a), 32'd15872);
      end

      // 6: asynchronous reset mid-fill at beat 30
      for (int k = 5; k <= 30; k++) begin
         ra = 8'($urandom());
         rb = 8'($urandom());
         cyc(1, ra, rb, 0, 0);
      end
      #2;
      reset = 1'b0;
      #1;
      m_busy   = 0;
      m_all_in = 0;
      m_k      = 0;
      e_we     = 0;
      e_done   = 0;
      e_addr_a = 2 * BASE_PAIR;
      e_addr_b = 2 * BASE_PAIR + 1;
      e_wa     = 0;
      e_wb     = 0;
      check_ports();
      chk("async_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) cyc(1, 8'hAA, 8'h55, 0, 0);
      cyc(0, 8'd0, 8'd0, 1, 0);
      cyc(1, 8'h11, 8'h22, 0, 0);
      chk("post_reset_addr_a", 32'(addr_a), 32'd15872);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
